// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words and writes
// them to consecutive instruction-memory addresses, holding the CPU in reset
// until the image is complete.
module imem_loader #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic [ADDR_W:0]   word_count,
    output logic              cpu_hold
);

    localparam int unsigned WC_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [23:0]       word_q, word_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic              last_q, last_d;
    logic [WC_W-1:0]   word_count_q, word_count_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cpu_hold_q, cpu_hold_d;

    logic              xfer_c;
    logic [31:0]       packed_c;

    // Complete word as it would look if this byte ends it (zero-padded low bytes)
    always_comb begin
        packed_c = 32'h0;
        unique case (byte_cnt_q)
            2'd0: packed_c = {in_data, 24'h0};
            2'd1: packed_c = {word_q[7:0], in_data, 16'h0};
            2'd2: packed_c = {word_q[15:0], in_data, 8'h0};
            2'd3: packed_c = {word_q[23:0], in_data};
            default: packed_c = 32'h0;
        endcase
    end

    assign xfer_c = in_valid && in_ready_q;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        word_d       = word_q;
        byte_cnt_d   = byte_cnt_q;
        last_d       = last_q;
        word_count_d = word_count_q;
        err_d        = err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RECV;
                    addr_d       = '0;
                    byte_cnt_d   = 2'd0;
                    word_count_d = '0;
                    err_d        = 1'b0;
                    last_d       = 1'b0;
                end
            end
            RECV: begin
                if (xfer_c) begin
                    word_d     = {word_q[15:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if ((byte_cnt_q == 2'd3) || in_last) begin
                        state_d     = WRITE;
                        last_d      = in_last;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = packed_c;
                    end
                end
            end
            WRITE: begin
                word_count_d = word_count_q + WC_W'(1);
                byte_cnt_d   = 2'd0;
                if (last_q) begin
                    state_d = DONE;
                end else if (addr_q == ADDR_MAX) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = RECV;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == RECV);
        busy_d     = (state_d == RECV) || (state_d == WRITE);
        mem_we_d   = (state_d == WRITE);
        done_d     = (state_d == DONE);
        cpu_hold_d = (state_d != DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            word_q       <= 24'h0;
            byte_cnt_q   <= 2'd0;
            last_q       <= 1'b0;
            word_count_q <= '0;
            err_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            mem_we_q     <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
            byte_cnt_q   <= byte_cnt_d;
            last_q       <= last_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_ovf    = err_q;
    assign word_count = word_count_q;
    assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scenario tasks with a write scoreboard for imem_loader.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err_ovf;
    logic [ADDR_W:0]   word_count;
    logic              cpu_hold;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_exp;
    int  errors = 0;
    int  checks = 0;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err_ovf    (err_ovf),
        .word_count (word_count),
        .cpu_hold   (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every memory write must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== mon_exp) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                             mem_addr, mem_wdata, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Offer one byte; returns at the negedge before the accepting posedge
    task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps,
                             input int budget, output bit accepted);
        accepted = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0; in_data = 8'hEE; in_last = 1'b1;
            end else begin
                in_valid = 1'b1; in_data = b; in_last = last;
                if (in_ready) begin
                    accepted = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w,
                             input logic last, input bit gaps);
        bit acc;
        logic [7:0] b;
        exp_q.push_back('{addr: a, data: w});
        for (int k = 0; k < 4; k++) begin
            b = w[31 - 8*k -: 8];
            send_byte(b, last && (k == 3), gaps, 40, acc);
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL byte_timeout word=%h byte=%0d", w, k);
            end
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s done_timeout got done=%b want 1", name, done);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_writes got pending=%0d want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({in_ready, mem_we, busy, done, err_ovf, cpu_hold} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags got rdy/we/busy/done/err/hold=%b want 000001",
                     {in_ready, mem_we, busy, done, err_ovf, cpu_hold});
        end
        checks++;
        if ({mem_addr, mem_wdata, word_count} !== '0) begin
            errors++;
            $display("FAIL reset_values got addr=%0d data=%h wc=%0d want 0",
                     mem_addr, mem_wdata, word_count);
        end
    endtask

    task automatic test_single_word();
        pulse_start();
        checks++;
        if (!(busy && in_ready && cpu_hold)) begin
            errors++;
            $display("FAIL single_recv got busy=%b rdy=%b hold=%b want 111", busy, in_ready, cpu_hold);
        end
        send_word('0, 32'h20080005, 1'b1, 1'b0);
        idle();
        wait_done("single");
        check_drained("single");
        checks++;
        if ({done, cpu_hold, busy, word_count} !== {3'b100, 6'd1}) begin
            errors++;
            $display("FAIL single_status got done=%b hold=%b busy=%b wc=%0d want 1 0 0 1",
                     done, cpu_hold, busy, word_count);
        end
    endtask

    task automatic test_random_valid();
        logic [31:0] w;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            send_word(ADDR_W'(i), w, i == 2, 1'b1);
        end
        idle();
        wait_done("random");
        check_drained("random");
        checks++;
        if (word_count !== 6'd3) begin
            errors++;
            $display("FAIL random_count got wc=%0d want 3", word_count);
        end
    endtask

    task automatic test_partial_word();
        bit acc;
        pulse_start();
        exp_q.push_back('{addr: '0, data: 32'hAABB0000});
        send_byte(8'hAA, 1'b0, 1'b0, 20, acc);
        send_byte(8'hBB, 1'b1, 1'b0, 20, acc);
        idle();
        wait_done("partial");
        check_drained("partial");
        repeat (3) @(negedge clk);
        checks++;
        if ({done, mem_we, mem_addr, mem_wdata, word_count} !== {2'b10, 5'd0, 32'hAABB0000, 6'd1}) begin
            errors++;
            $display("FAIL partial_hold got done=%b we=%b addr=%0d data=%h wc=%0d want 1 0 0 aabb0000 1",
                     done, mem_we, mem_addr, mem_wdata, word_count);
        end
    endtask

    task automatic test_overflow();
        bit acc;
        pulse_start();
        for (int i = 0; i < 32; i++)
            send_word(ADDR_W'(i), 32'hC0DE0000 + 32'(i), 1'b0, 1'b0);
        idle();
        wait_done("overflow");
        check_drained("overflow");
        checks++;
        if ({err_ovf, done, in_ready, busy, word_count} !== {4'b1100, 6'd32}) begin
            errors++;
            $display("FAIL overflow_status got err=%b done=%b rdy=%b busy=%b wc=%0d want 1 1 0 0 32",
                     err_ovf, done, in_ready, busy, word_count);
        end
        send_byte(8'h99, 1'b0, 1'b0, 8, acc);
        idle();
        checks++;
        if (acc !== 1'b0) begin
            errors++;
            $display("FAIL overflow_33rd got accepted=%b want 0", acc);
        end
    endtask

    task automatic test_reset_midload();
        bit acc;
        pulse_start();
        checks++;
        if (err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_err got err=%b want 0", err_ovf);
        end
        send_byte(8'h11, 1'b0, 1'b0, 20, acc);
        send_byte(8'h22, 1'b0, 1'b0, 20, acc);
        idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, busy, done, err_ovf, cpu_hold, word_count} !== {6'b000001, 6'd0}) begin
            errors++;
            $display("FAIL midreset got rdy/we/busy/done/err/hold=%b wc=%0d want 000001 0",
                     {in_ready, mem_we, busy, done, err_ovf, cpu_hold}, word_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        send_word('0, 32'h13579BDF, 1'b1, 1'b0);
        idle();
        wait_done("reload");
        check_drained("reload");
        checks++;
        if (word_count !== 6'd1) begin
            errors++;
            $display("FAIL reload_count got wc=%0d want 1", word_count);
        end
    endtask

    task automatic test_start_ignored();
        pulse_start();
        send_word(5'd0, 32'hDEADBEEF, 1'b0, 1'b0);
        idle();
        repeat (2) @(negedge clk);
        pulse_start();
        send_word(5'd1, 32'h01234567, 1'b1, 1'b0);
        idle();
        wait_done("ignored");
        check_drained("ignored");
        checks++;
        if (word_count !== 6'd2) begin
            errors++;
            $display("FAIL ignored_count got wc=%0d want 2", word_count);
        end
        pulse_start();
        checks++;
        if ({done, cpu_hold, busy, in_ready, word_count} !== {4'b0111, 6'd0}) begin
            errors++;
            $display("FAIL restart got done=%b hold=%b busy=%b rdy=%b wc=%0d want 0 1 1 1 0",
                     done, cpu_hold, busy, in_ready, word_count);
        end
        send_word(5'd0, 32'hFEEDF00D, 1'b1, 1'b0);
        idle();
        wait_done("restart");
        check_drained("restart");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_random_valid();
        test_partial_word();
        test_overflow();
        test_reset_midload();
        test_start_ignored();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
